// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package dbus_pkg;

   typedef enum logic {IDLE, WAIT_RD} dbus_state_t;

   typedef logic mst_idx_t;

   localparam int DBUS_DATA_WIDTH = 32;

   // Data returned to the owner when a read is terminated by the watchdog
   localparam logic [DBUS_DATA_WIDTH-1:0] TIMEOUT_DATA = DBUS_DATA_WIDTH'(32'hDEAD_BEEF);

   // The master that was not just served becomes the favoured one
   function automatic mst_idx_t other_mst(input mst_idx_t m);
      return ~m;
   endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of both master ports plus the RAM port of the data bus arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface data_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic                  m0_gnt;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_rvalid;
   logic                  m0_err;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic                  m1_gnt;
   logic [DATA_WIDTH-1:0] m1_rdata;
   logic                  m1_rvalid;
   logic                  m1_err;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_rdata, mem_rvalid,
      output m0_gnt, m0_rdata, m0_rvalid, m0_err,
      output m1_gnt, m1_rdata, m1_rvalid, m1_err,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_rdata, mem_rvalid,
      input  m0_gnt, m0_rdata, m0_rvalid, m0_err,
      input  m1_gnt, m1_rdata, m1_rvalid, m1_err,
      input  mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-input round-robin selector.
module rr_pick2
   import dbus_pkg::*;
(
   input  logic [1:0] req,
   input  mst_idx_t   prio,
   output logic       valid,
   output mst_idx_t   sel
);

   // A lone requester wins outright; on a tie the favoured master wins
   always_comb begin
      valid = |req;
      sel   = (req == 2'b11) ? prio : req[1];
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the single-port data RAM. Writes complete
// in the grant cycle; reads park the FSM in WAIT_RD until the RAM returns
// valid data or the watchdog forces a completion with TIMEOUT_DATA.
module data_bus_arbiter
   import dbus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              reset,
   data_bus_arbiter_if.slave bus
);

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

   dbus_state_t           state_q;
   mst_idx_t              prio_q;
   mst_idx_t              owner_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            wd_cnt_q;

   logic                  pick_vld;
   mst_idx_t              pick_sel;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  rd_timeout;
   logic                  rd_done;
   logic [DATA_WIDTH-1:0] rd_data;

   rr_pick2 u_pick (
      .req   ({bus.m1_req, bus.m0_req}),
      .prio  (prio_q),
      .valid (pick_vld),
      .sel   (pick_sel)
   );

   // Command of the selected master, and read completion conditions
   always_comb begin
      sel_we     = pick_sel ? bus.m1_we    : bus.m0_we;
      sel_addr   = pick_sel ? bus.m1_addr  : bus.m0_addr;
      sel_wdata  = pick_sel ? bus.m1_wdata : bus.m0_wdata;
      // Real data wins over the watchdog when both land in the same cycle
      rd_timeout = (state_q == WAIT_RD) && !bus.mem_rvalid && (wd_cnt_q == WD_LIMIT);
      rd_done    = (state_q == WAIT_RD) && (bus.mem_rvalid || rd_timeout);
      rd_data    = rd_timeout ? DATA_WIDTH'(TIMEOUT_DATA) : bus.mem_rdata;
   end

   // Grant, RAM command and read return routing; all quiet while in reset
   always_comb begin
      bus.m0_gnt    = 1'b0;
      bus.m1_gnt    = 1'b0;
      bus.m0_rvalid = 1'b0;
      bus.m1_rvalid = 1'b0;
      bus.m0_err    = 1'b0;
      bus.m1_err    = 1'b0;
      bus.m0_rdata  = '0;
      bus.m1_rdata  = '0;
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      if (!reset) begin
         if (state_q == IDLE) begin
            if (pick_vld) begin
               bus.m0_gnt    = !pick_sel;
               bus.m1_gnt    = pick_sel;
               bus.mem_addr  = sel_addr;
               bus.mem_we    = sel_we;
               bus.mem_wdata = sel_wdata;
            end
         end else begin
            bus.mem_addr = addr_q;
            if (rd_done) begin
               if (owner_q) begin
                  bus.m1_rvalid = 1'b1;
                  bus.m1_err    = rd_timeout;
                  bus.m1_rdata  = rd_data;
               end else begin
                  bus.m0_rvalid = 1'b1;
                  bus.m0_err    = rd_timeout;
                  bus.m0_rdata  = rd_data;
               end
            end
         end
      end
   end

   // FSM, fairness pointer, outstanding-read tracking and watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         addr_q   <= '0;
         wd_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  prio_q <= other_mst(pick_sel);
                  if (!sel_we) begin
                     state_q  <= WAIT_RD;
                     owner_q  <= pick_sel;
                     addr_q   <= sel_addr;
                     wd_cnt_q <= '0;
                  end
               end
            end
            WAIT_RD: begin
               wd_cnt_q <= wd_cnt_q + 8'd1;
               if (rd_done) state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single-port data RAM between the DLX data port (master 0) and a second bus master such as a DMA or VGA frame reader (master 1). It sits between the masters and the RAM's address, write, read and read-valid pins. It grants one access at a time with round-robin fairness and tracks each outstanding read until the RAM signals valid data. A watchdog terminates any read that never completes.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte-address width of master and memory ports
- DATA_WIDTH, 32, data word width
- TIMEOUT, 15, maximum cycles spent in WAIT_RD before a forced completion (1..255)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held high until the matching gnt
- m0_we / m1_we  in  1  1 = write, 0 = read; valid while req is high
- m0_addr / m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_gnt / m1_gnt  out  1  one-cycle pulse; the request is accepted this cycle
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid when rvalid is high
- m0_rvalid / m1_rvalid  out  1  one-cycle read completion pulse
- m0_err / m1_err  out  1  one-cycle pulse together with rvalid on a timeout completion
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data
- mem_rvalid  in  1  RAM read-data-valid

## Operation

- The FSM has two states: IDLE and WAIT_RD. It also keeps these registers:
  - prio: the master favoured on a tie; reset value 0.
  - owner: the master whose read is outstanding.
  - addr_q: the latched address of that read.
  - wd_cnt: an 8-bit watchdog counter.
- IDLE, no request:
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - All gnt signals low.
- IDLE, one or both requests:
  - Selection: if only one master requests, it is selected. If both request, the master indicated by prio is selected.
  - Grant: the selected master's gnt is driven high combinationally in the same cycle.
  - Memory command: mem_addr and mem_wdata come from the selected master. mem_we equals the selected master's we.
  - Fairness: on the next edge, prio is set to the master that was not selected.
- Write grant: the access completes in the grant cycle and the FSM stays in IDLE. A new grant is therefore possible every cycle for back-to-back writes.
- Read grant: on the next edge the FSM loads owner and addr_q, clears wd_cnt and moves to WAIT_RD.
- WAIT_RD:
  - mem_addr holds addr_q and mem_we = 0.
  - No gnt is issued.
  - wd_cnt increments every cycle.
- Normal read completion: when mem_rvalid = 1, the owner's rvalid is driven to 1 (combinational) and its rdata to mem_rdata. The FSM returns to IDLE on the next edge.
- Timeout: if wd_cnt reaches TIMEOUT with mem_rvalid still low:
  - the owner's rvalid and err are both 1 for that cycle;
  - its rdata = 32'hDEAD_BEEF;
  - the FSM returns to IDLE.
- Priority rule: if mem_rvalid is 1 in the same cycle wd_cnt reaches TIMEOUT, the real data wins and err stays low.
- mem_rvalid in IDLE is ignored; no rvalid pulse is produced. This covers stale data after a reset or timeout.
- rdata of the master that is not the owner is held at 0.

## Timing

- Reset values: state = IDLE, prio = 0, wd_cnt = 0, owner = 0, addr_q = 0. All gnt, rvalid and err outputs are 0, mem_we = 0 and mem_addr = 0.
- Grant latency: 0 cycles. gnt appears in the same cycle as req when the FSM is in IDLE.
- Read latency with a RAM valid one cycle after the address (as the data RAM behaves):
  - grant in cycle N;
  - WAIT_RD and mem_rvalid in cycle N+1;
  - rvalid in cycle N+1;
  - next grant possible in cycle N+2.
- A request that arrives during WAIT_RD waits and is arbitrated in the first IDLE cycle.
- Reset asserted mid-read: the next edge forces IDLE. No rvalid is emitted for the aborted read.

## Structure

- Package dbus_pkg holds:
  - typedef enum logic {IDLE, WAIT_RD} dbus_state_t;
  - typedef logic mst_idx_t;
  - localparam DATA_WIDTH'hDEAD_BEEF TIMEOUT_DATA.
- Sub-module rr_pick2: combinational two-input round-robin selector.
  - Inputs: req[1:0], prio.
  - Outputs: valid, sel.
- The FSM, watchdog and routing live in data_bus_arbiter.

## Test plan

- Reset then idle: all outputs 0 for 5 cycles; mem_rvalid = 1 in IDLE gives no rvalid pulse.
- m0 writes 0x1234_5678 to address 0x40 → m0_gnt and mem_we high in the same cycle, mem_addr = 0x40; the next grant is possible in the following cycle.
- Both masters request reads every cycle, RAM valid after one cycle → grants alternate m0, m1, m0, m1; each rvalid goes to the correct owner with the matching data.
- m1 reads 0x80 and the RAM never asserts valid (TIMEOUT = 15) → m1_rvalid and m1_err are 1 on the 16th WAIT_RD cycle, rdata = 0xDEAD_BEEF, then IDLE.
- mem_rvalid coincides with the timeout cycle → real data is delivered and err stays 0.
- Reset asserted during WAIT_RD followed by a late mem_rvalid → no rvalid pulse; the next m0 request is granted normally with prio = 0.
